s420_z_frame_collector: RTL

// Downstream stage of the s420 sequence-select counter. Samples the counter's

---
 rtl/s420_z_frame_collector.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/s420_z_frame_collector.sv
// Packs Z samples taken on enabled s420 count steps into FRAME_LEN-bit frames
// and queues them, with their ones-count, in a 2-entry valid/ready output FIFO.
module s420_z_frame_collector #(
  parameter  int FRAME_LEN = 16,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 P_0,
  input  logic                 Z,
  input  logic                 SYNC,
  input  logic                 FRAME_READY,
  output logic                 FRAME_VALID,
  output logic [FRAME_LEN-1:0] FRAME_DATA,
  output logic [CNT_W-1:0]     FRAME_ONES,
  output logic                 OVERFLOW,
  output logic [CNT_W-1:0]     IDX
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {COLLECT, LAST} state_e;

  state_e               state;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     ones_q, ones_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;

  logic                 push;
  logic [FRAME_LEN-1:0] push_data;
  logic [CNT_W-1:0]     push_ones;
  logic                 pop;

  logic [FRAME_LEN-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [CNT_W-1:0]     head_ones_q, head_ones_d, tail_ones_q, tail_ones_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  // The state is not stored separately; it is the decode of the sample index.
  always_comb state = (idx_q == LAST_IDX) ? LAST : COLLECT;

  assign push_data = {Z, shift_q[FRAME_LEN-2:0]};
  assign push_ones = ones_q + CNT_W'(Z);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    idx_d   = idx_q;
    shift_d = shift_q;
    ones_d  = ones_q;
    push    = 1'b0;
    if (SYNC) begin
      idx_d   = '0;
      shift_d = '0;
      ones_d  = '0;
      if (P_0) begin
        idx_d   = CNT_W'(1);
        shift_d = FRAME_LEN'(Z);
        ones_d  = CNT_W'(Z);
      end
    end else if (P_0) begin
      case (state)
        COLLECT: begin
          shift_d = shift_q | (FRAME_LEN'(Z) << idx_q);
          ones_d  = push_ones;
          idx_d   = idx_q + CNT_W'(1);
        end
        LAST: begin
          push    = 1'b1;
          idx_d   = '0;
          shift_d = '0;
          ones_d  = '0;
        end
        default: ;
      endcase
    end
  end

  assign pop = (cnt_q != 2'd0) && FRAME_READY;

  // Head register drives the outputs directly; it keeps its value after the last pop.
  always_comb begin
    head_data_d = head_data_q;
    head_ones_d = head_ones_q;
    tail_data_d = tail_data_q;
    tail_ones_d = tail_ones_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_data_d = push_data;
          head_ones_d = push_ones;
          cnt_d       = 2'd1;
        end
      end
      2'd1: begin
        if (pop && push) begin
          head_data_d = push_data;
          head_ones_d = push_ones;
        end else if (pop) begin
          cnt_d = 2'd0;
        end else if (push) begin
          tail_data_d = push_data;
          tail_ones_d = push_ones;
          cnt_d       = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_ones_d = tail_ones_q;
          if (push) begin
            tail_data_d = push_data;
            tail_ones_d = push_ones;
          end else begin
            cnt_d = 2'd1;
          end
        end else if (push) begin
          ovf_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RN) begin
      idx_q       <= '0;
      ones_q      <= '0;
      shift_q     <= '0;
      // NOTE: the FIFO storage is reset as well because the head entry is visible on FRAME_DATA/FRAME_ONES.
      head_data_q <= '0;
      head_ones_q <= '0;
      tail_data_q <= '0;
      tail_ones_q <= '0;
      cnt_q       <= 2'd0;
      ovf_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      ones_q      <= ones_d;
      shift_q     <= shift_d;
      head_data_q <= head_data_d;
      head_ones_q <= head_ones_d;
      tail_data_q <= tail_data_d;
      tail_ones_q <= tail_ones_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign FRAME_VALID = (cnt_q != 2'd0);
  assign FRAME_DATA  = head_data_q;
  assign FRAME_ONES  = head_ones_q;
  assign OVERFLOW    = ovf_q;
  assign IDX         = idx_q;

endmodule
